cg_sequencer: RTL
=================

CG_SEQUENCER -- requirements
Module: cg_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- number_of_clusters, 40, clusters swept per matrix-vector pass.
- memory_read_address_width, 20, width of address outputs.
- max_iterations, 64, iteration limit; must be at least 1.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous active-low reset.
- start_solve, in, 1, request a solve; sampled only in IDLE.
- abort, in, 1, synchronous abort of a running solve.
- mXv1_finish, in, 1, matrix-vector unit finished the current cluster.
- vXv1_finish, in, 1, dot-product unit finished.
- finish, in, 1, ALU vector-update step finished.
- finish_all, in, 1, ALU convergence flag; sampled in CHECK only.
- reset_mXv1, out, 1, active-high restart pulse to the matrix-vector unit.
- reset_vXv1, out, 1, active-high restart pulse to the dot-product unit.
- memoryA_read_address, out, memory_read_address_width, current cluster index.
- memoryR_read_address, out, memory_read_address_width, residual sweep address.
- memoryRprev_we, out, 1, write enable for the previous-residual store.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle completion pulse.
- converged, out, 1, result flag for the last solve.
- iteration_count, out, 16, completed-iteration counter.
- phase, out, 3, state encoding.

Function
REQ-003 States and phase encoding: IDLE=0, MXV_ARM=1, MXV_WAIT=2, DOT_ARM=3, DOT_WAIT=4, UPDATE=5, CHECK=6, DONE=7.
REQ-004 Start:
- IDLE with start_solve=1 -> MXV_ARM next cycle.
- Same edge clears cluster index, iteration_count, converged.
- start_solve is ignored in every other state.
REQ-005 MXV_ARM: lasts exactly 1 cycle, asserts reset_mXv1=1, drives memoryA_read_address=cluster index, then -> MXV_WAIT.
REQ-006 MXV_WAIT: memoryA_read_address holds; on mXv1_finish=1:
- Cluster index < number_of_clusters-1: increment index, -> MXV_ARM.
- Otherwise: index -> 0, -> DOT_ARM.
REQ-007 DOT_ARM: lasts 1 cycle, asserts reset_vXv1=1, -> DOT_WAIT. DOT_WAIT -> UPDATE on vXv1_finish=1.
REQ-008 UPDATE sweep:
- On entry, memoryR_read_address=0.
- Address increments by 1 per cycle, with memoryRprev_we=1 each cycle, through number_of_clusters-1.
- After the last address, memoryRprev_we=0 and address holds until finish=1, then -> CHECK.
- A finish arriving during the sweep is held pending and honoured after the sweep.
REQ-009 CHECK lasts 1 cycle:
- finish_all=1: converged=1, -> DONE.
- Else iteration_count = max_iterations-1: converged=0, -> DONE.
- Else iteration_count+1, -> MXV_ARM.
REQ-010 DONE lasts 1 cycle with done=1, then -> IDLE. converged holds until the next accepted start.
REQ-011 Finish and flag inputs arriving in states that do not wait on them are ignored and are not remembered.
REQ-012 abort=1 in any non-IDLE state:
- -> IDLE next cycle.
- done is not pulsed, converged=0, iteration_count holds, memoryRprev_we=0 that cycle.
- abort has priority over all simultaneous finish inputs.
REQ-013 In IDLE and DONE, reset_mXv1 and reset_vXv1 both equal 1, so the units are held reset. In all other states they are 0 except as required by REQ-005 and REQ-007.
REQ-014 iteration_count saturates at 16'hFFFF and never wraps.
REQ-015 All outputs are registered. Latency from an accepted start_solve to the first reset_mXv1 pulse is 1 cycle.

Reset
REQ-016 Reset low, asynchronously: state=IDLE; reset_mXv1=1, reset_vXv1=1; addresses=0; memoryRprev_we=0, busy=0, done=0, converged=0, iteration_count=0, phase=0.
REQ-017 Reset asserted mid-solve takes effect immediately. After release the block waits in IDLE for a new start_solve.

Verification
REQ-018 Bench parameters: number_of_clusters=3, max_iterations=4.
REQ-019 Scenario, nominal convergence:
- start_solve; answer each finish 2 cycles after its arm pulse; finish_all=1 at the first CHECK.
- Expect: memoryA_read_address 0,1,2; three reset_mXv1 pulses; one reset_vXv1 pulse; memoryRprev_we high 3 cycles at addresses 0,1,2; done pulse; converged=1; iteration_count=0.
REQ-020 Scenario, iteration limit: finish_all always 0 -> exactly 4 passes, done pulse, converged=0, iteration_count=3.
REQ-021 Scenario, abort: assert abort during MXV_WAIT of cluster 1, together with mXv1_finish -> phase=0 next cycle, no done pulse, converged=0, iteration_count unchanged.
REQ-022 Scenario, stray inputs: pulse vXv1_finish during MXV_WAIT and finish during DOT_WAIT -> no state change; the later legitimate finish inputs are still required to advance.
REQ-023 Scenario, early finish: finish=1 at the second sweep cycle of UPDATE -> sweep completes through address 2, then CHECK on the following cycle.
REQ-024 Scenario, reset mid-operation: drive reset low during UPDATE -> all outputs at their REQ-016 values before the next clock edge; start_solve held high continuously afterwards starts a new solve.

Source files
------------

// File: rtl/cg_sequencer.sv
// Solve sequencer: arms the matrix-vector unit once per cluster, then the dot-product
// unit, sweeps the residual store, and checks convergence until done or out of iterations.
module cg_sequencer #(
  parameter int unsigned number_of_clusters        = 40,
  parameter int unsigned memory_read_address_width = 20,
  parameter int unsigned max_iterations            = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start_solve,
  input  logic                                 abort,
  input  logic                                 mXv1_finish,
  input  logic                                 vXv1_finish,
  input  logic                                 finish,
  input  logic                                 finish_all,
  output logic                                 reset_mXv1,
  output logic                                 reset_vXv1,
  output logic [memory_read_address_width-1:0] memoryA_read_address,
  output logic [memory_read_address_width-1:0] memoryR_read_address,
  output logic                                 memoryRprev_we,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 converged,
  output logic [15:0]                          iteration_count,
  output logic [2:0]                           phase
);
  localparam int unsigned   AW        = memory_read_address_width;
  localparam logic [AW-1:0] LAST_ADDR = AW'(number_of_clusters - 1);
  localparam logic [31:0]   LAST_ITER = 32'(max_iterations - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MXV_ARM  = 3'd1,
    S_MXV_WAIT = 3'd2,
    S_DOT_ARM  = 3'd3,
    S_DOT_WAIT = 3'd4,
    S_UPDATE   = 3'd5,
    S_CHECK    = 3'd6,
    S_DONE     = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clus_q, clus_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          sweep_q, sweep_d;
  logic          pending_q, pending_d;
  logic          conv_q, conv_d;
  logic [15:0]   iter_q, iter_d;
  logic          rst_mxv_q, rst_mxv_d;
  logic          rst_vxv_q, rst_vxv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    clus_d    = clus_q;
    raddr_d   = raddr_q;
    sweep_d   = 1'b0;
    pending_d = pending_q;
    conv_d    = conv_q;
    iter_d    = iter_q;

    if (state_q != S_IDLE && abort) begin
      state_d   = S_IDLE;
      conv_d    = 1'b0;
      pending_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_solve) begin
            state_d = S_MXV_ARM;
            clus_d  = '0;
            iter_d  = '0;
            conv_d  = 1'b0;
          end
        end
        S_MXV_ARM: state_d = S_MXV_WAIT;
        S_MXV_WAIT: begin
          if (mXv1_finish) begin
            if (clus_q < LAST_ADDR) begin
              clus_d  = clus_q + AW'(1);
              state_d = S_MXV_ARM;
            end else begin
              clus_d  = '0;
              state_d = S_DOT_ARM;
            end
          end
        end
        S_DOT_ARM: state_d = S_DOT_WAIT;
        S_DOT_WAIT: begin
          if (vXv1_finish) begin
            state_d   = S_UPDATE;
            raddr_d   = '0;
            sweep_d   = 1'b1;
            pending_d = 1'b0;
          end
        end
        S_UPDATE: begin
          // sweep_q marks the write-enabled sweep; a finish seen mid-sweep waits in pending_q
          if (sweep_q) begin
            if (raddr_q == LAST_ADDR) begin
              pending_d = 1'b0;
              if (finish || pending_q) state_d = S_CHECK;
            end else begin
              raddr_d   = raddr_q + AW'(1);
              sweep_d   = 1'b1;
              pending_d = pending_q | finish;
            end
          end else if (finish) begin
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (finish_all) begin
            conv_d  = 1'b1;
            state_d = S_DONE;
          end else if ({16'd0, iter_q} >= LAST_ITER) begin
            conv_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            if (iter_q != 16'hFFFF) iter_d = iter_q + 16'd1;
            state_d = S_MXV_ARM;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    rst_mxv_d = state_d inside {S_IDLE, S_MXV_ARM, S_DONE};
    rst_vxv_d = state_d inside {S_IDLE, S_DOT_ARM, S_DONE};
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      clus_q    <= '0;
      raddr_q   <= '0;
      sweep_q   <= 1'b0;
      pending_q <= 1'b0;
      conv_q    <= 1'b0;
      iter_q    <= '0;
      rst_mxv_q <= 1'b1;
      rst_vxv_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clus_q    <= clus_d;
      raddr_q   <= raddr_d;
      sweep_q   <= sweep_d;
      pending_q <= pending_d;
      conv_q    <= conv_d;
      iter_q    <= iter_d;
      rst_mxv_q <= rst_mxv_d;
      rst_vxv_q <= rst_vxv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign reset_mXv1           = rst_mxv_q;
  assign reset_vXv1           = rst_vxv_q;
  assign memoryA_read_address = clus_q;
  assign memoryR_read_address = raddr_q;
  assign memoryRprev_we       = sweep_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign converged            = conv_q;
  assign iteration_count      = iter_q;
  assign phase                = state_q;
endmodule
